// File: rtl/port_extend_arbiter_if.sv
// Requester-side and consumer-side signals of the shared width-extension stage.
// slave is the arbiter's view, master the view of the surrounding requesters/consumer.
interface port_extend_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 3,
    parameter int OUT_W = 4
);
    localparam int LW  = $clog2(IN_W + 1);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*IN_W-1:0] req_data;
    logic [NREQ*LW-1:0]   req_len;
    logic [NREQ-1:0]      req_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_data;
    logic [IDW-1:0]       out_id;
    logic [15:0]          grant_cnt;

    modport slave (
        input  req_valid, req_data, req_len, req_signed, out_ready,
        output req_ready, out_valid, out_data, out_id, grant_cnt
    );

    modport master (
        output req_valid, req_data, req_len, req_signed, out_ready,
        input  req_ready, out_valid, out_data, out_id, grant_cnt
    );
endinterface

// File: rtl/port_extend_arbiter.sv
// Round-robin shared sign/zero extension stage; result registered one cycle after accept.
// Backpressure: a held result (out_valid && !out_ready) blocks all req_ready.
module port_extend_arbiter #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 3,
    parameter int OUT_W = 4
) (
    input logic                   clk,
    input logic                   rst,
    port_extend_arbiter_if.slave  bus
);
    localparam int LW  = $clog2(IN_W + 1);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state;
    logic [IDW-1:0]   last_grant;
    logic [IDW-1:0]   out_id_q;
    logic [OUT_W-1:0] out_data_q;
    logic [15:0]      grant_cnt_q;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    int               cand;
    logic             accept;
    logic [NREQ-1:0]  ready;

    logic [IN_W-1:0]  sel_data;
    logic [LW-1:0]    sel_len;
    logic [LW-1:0]    len;
    logic             sel_signed;
    logic [OUT_W-1:0] data_w;
    logic [OUT_W-1:0] keep_mask;
    logic [OUT_W-1:0] shifted;
    logic             fill;
    logic [OUT_W-1:0] ext_data;

    // Search starts one past the last grant and wraps, so every requester gets a turn.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant) + k) % NREQ;
            if (!gnt_found && bus.req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    assign accept = !rst && ((state == EMPTY) || bus.out_ready) && gnt_found;

    always_comb begin
        ready = '0;
        if (accept) begin
            ready[gnt_idx] = 1'b1;
        end
    end

    assign sel_data   = bus.req_data[int'(gnt_idx)*IN_W +: IN_W];
    assign sel_len    = bus.req_len[int'(gnt_idx)*LW +: LW];
    assign sel_signed = bus.req_signed[gnt_idx];

    // Lengths beyond the source width mean "use the whole source".
    assign len       = (sel_len > LW'(IN_W)) ? LW'(IN_W) : sel_len;
    assign data_w    = OUT_W'(sel_data);
    assign keep_mask = (OUT_W'(1) << len) - OUT_W'(1);
    assign shifted   = data_w >> (len - LW'(1));
    assign fill      = sel_signed && (len != '0) && shifted[0];
    assign ext_data  = (data_w & keep_mask) | (fill ? ~keep_mask : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            out_data_q  <= '0;
            out_id_q    <= '0;
            grant_cnt_q <= '0;
            last_grant  <= IDW'(NREQ - 1);
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (bus.out_ready && !accept) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (accept) begin
                out_data_q  <= ext_data;
                out_id_q    <= gnt_idx;
                last_grant  <= gnt_idx;
                grant_cnt_q <= grant_cnt_q + 16'd1;
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign bus.grant_cnt = grant_cnt_q;
endmodule

// File: tb/tb_port_extend_arbiter.sv
// Scenario bench for port_extend_arbiter: expected results queued at accept, compared when output appears.
module tb_port_extend_arbiter;
    localparam int NREQ  = 4;
    localparam int IN_W  = 3;
    localparam int OUT_W = 4;
    localparam int LW    = $clog2(IN_W + 1);
    localparam int IDW   = $clog2(NREQ);

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [IDW-1:0]   id;
    } exp_t;

    typedef struct {
        int           i;
        logic [2:0]   d;
        int           len;
        logic         s;
        logic [3:0]   exp;
    } case_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    int   model_last;
    int   model_cnt;
    exp_t q[$];

    case_t cases[10] = '{
        '{0, 3'b001, 1, 1'b0, 4'b0001},
        '{1, 3'b001, 1, 1'b1, 4'b1111},
        '{2, 3'b010, 2, 1'b1, 4'b1110},
        '{3, 3'b010, 2, 1'b0, 4'b0010},
        '{0, 3'b101, 3, 1'b1, 4'b1101},
        '{1, 3'b111, 0, 1'b1, 4'b0000},
        '{2, 3'b101, 7, 1'b1, 4'b1101},
        '{3, 3'b111, 0, 1'b0, 4'b0000},
        '{0, 3'b110, 2, 1'b1, 4'b1110},
        '{1, 3'b011, 3, 1'b1, 4'b0011}
    };

    port_extend_arbiter_if #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    port_extend_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] ext_model(input logic [IN_W-1:0] d, input int len, input logic s);
        logic [OUT_W-1:0] r;
        int L;
        L = (len > IN_W) ? IN_W : len;
        r = '0;
        for (int b = 0; b < OUT_W; b++) begin
            if (b < L)               r[b] = d[b];
            else if (s && (L > 0))   r[b] = d[L-1];
            else                     r[b] = 1'b0;
        end
        return r;
    endfunction

    function automatic int model_grant(input logic [NREQ-1:0] v);
        int g;
        g = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (model_last + k) % NREQ;
            if (g < 0 && v[c]) g = c;
        end
        return g;
    endfunction

    function automatic logic [OUT_W-1:0] model_of(input int g);
        return ext_model(bus.req_data[g*IN_W +: IN_W], int'(bus.req_len[g*LW +: LW]), bus.req_signed[g]);
    endfunction

    task automatic set_req(input int i, input logic [IN_W-1:0] d, input int len, input logic s);
        bus.req_data[i*IN_W +: IN_W] = d;
        bus.req_len[i*LW +: LW]      = LW'(len);
        bus.req_signed[i]            = s;
        bus.req_valid[i]             = 1'b1;
    endtask

    task automatic note_accept(input int g, input logic [OUT_W-1:0] d);
        exp_t e;
        e.data = d;
        e.id   = IDW'(g);
        q.push_back(e);
        model_last = g;
        model_cnt++;
    endtask

    task automatic model_reset();
        model_last = NREQ - 1;
        model_cnt  = 0;
        q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '1;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if (bus.req_ready !== '0) begin tests_failed++; $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready); end
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        tests_run++;
        if (bus.out_data !== '0 || bus.out_id !== '0) begin tests_failed++; $display("FAIL reset_out got data=%b id=%0d want 0/0", bus.out_data, bus.out_id); end
        tests_run++;
        if (bus.grant_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_grant_cnt got=%0d want=0", bus.grant_cnt); end
        rst = 1'b0;
        bus.req_valid = '0;
        model_reset();
    endtask

    task automatic test_extend();
        exp_t e;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            bus.req_valid = '0;
            set_req(cases[n].i, cases[n].d, cases[n].len, cases[n].s);
            bus.out_ready = 1'b1;
            #1;
            tests_run++;
            if (bus.req_ready !== (NREQ'(1) << cases[n].i)) begin
                tests_failed++;
                $display("FAIL extend_ready[%0d] got=%b want req %0d", n, bus.req_ready, cases[n].i);
            end
            note_accept(cases[n].i, cases[n].exp);
            @(negedge clk);
            bus.req_valid = '0;
            #1;
            e = q.pop_front();
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_id !== e.id) begin
                tests_failed++;
                $display("FAIL extend_out[%0d] got v=%b data=%b id=%0d want v=1 data=%b id=%0d",
                         n, bus.out_valid, bus.out_data, bus.out_id, e.data, e.id);
            end
            tests_run++;
            if (bus.grant_cnt !== 16'(model_cnt)) begin
                tests_failed++;
                $display("FAIL extend_cnt[%0d] got=%0d want=%0d", n, bus.grant_cnt, model_cnt);
            end
        end
    endtask

    task automatic test_round_robin();
        int seq[5] = '{0, 1, 2, 3, 0};
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, IN_W'(2*i + 1), 3, 1'b0);
        bus.out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            if (n == 5) bus.req_valid = '0;
            #1;
            if (n > 0) begin
                e = q.pop_front();
                tests_run++;
                if (bus.out_valid !== 1'b1 || bus.out_id !== e.id || bus.out_data !== e.data) begin
                    tests_failed++;
                    $display("FAIL rr_out[%0d] got v=%b id=%0d data=%b want v=1 id=%0d data=%b",
                             n, bus.out_valid, bus.out_id, bus.out_data, e.id, e.data);
                end
            end
            if (n < 5) begin
                tests_run++;
                if (bus.req_ready !== (NREQ'(1) << seq[n]) || !$onehot(bus.req_ready)) begin
                    tests_failed++;
                    $display("FAIL rr_ready[%0d] got=%b want req %0d", n, bus.req_ready, seq[n]);
                end
                note_accept(seq[n], model_of(seq[n]));
            end
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (bus.grant_cnt !== 16'd5 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_cnt got cnt=%0d v=%b want cnt=5 v=0", bus.grant_cnt, bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int g;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.req_valid = '0;
        set_req(1, 3'b011, 2, 1'b1);
        set_req(2, 3'b100, 3, 1'b0);
        #1;
        g = model_grant(bus.req_valid);
        tests_run++;
        if (bus.req_ready !== (NREQ'(1) << g)) begin tests_failed++; $display("FAIL bp_first_ready got=%b want req %0d", bus.req_ready, g); end
        note_accept(g, model_of(g));
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (n == 1) set_req(2, 3'b110, 2, 1'b1);
            #1;
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.req_ready !== '0 || bus.out_data !== q[0].data || bus.out_id !== q[0].id) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d] got v=%b rdy=%b data=%b id=%0d want v=1 rdy=0000 data=%b id=%0d",
                         n, bus.out_valid, bus.req_ready, bus.out_data, bus.out_id, q[0].data, q[0].id);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        g = model_grant(bus.req_valid);
        tests_run++;
        if (bus.req_ready !== (NREQ'(1) << g)) begin tests_failed++; $display("FAIL bp_release_ready got=%b want req %0d", bus.req_ready, g); end
        e = q.pop_front();
        tests_run++;
        if (bus.out_data !== e.data || bus.out_id !== e.id) begin
            tests_failed++;
            $display("FAIL bp_held_out got data=%b id=%0d want data=%b id=%0d", bus.out_data, bus.out_id, e.data, e.id);
        end
        note_accept(g, model_of(g));
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        e = q.pop_front();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== e.data || bus.out_id !== e.id) begin
            tests_failed++;
            $display("FAIL bp_next_out got v=%b data=%b id=%0d want v=1 data=%b id=%0d",
                     bus.out_valid, bus.out_data, bus.out_id, e.data, e.id);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain got v=%b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int g;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.req_valid = '0;
        set_req(3, 3'b111, 3, 1'b1);
        #1;
        g = model_grant(bus.req_valid);
        note_accept(g, model_of(g));
        @(negedge clk);
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL rm_full got v=%b want 1", bus.out_valid); end
        rst = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.req_ready !== '0) begin tests_failed++; $display("FAIL rm_ready_in_reset got=%b want 0000", bus.req_ready); end
        @(negedge clk);
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.grant_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL rm_cleared got v=%b cnt=%0d want v=0 cnt=0", bus.out_valid, bus.grant_cnt);
        end
        model_reset();
        rst = 1'b0;
        bus.req_valid = '0;
        set_req(2, 3'b010, 2, 1'b1);
        set_req(0, 3'b011, 1, 1'b1);
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0001) begin tests_failed++; $display("FAIL rm_first_grant got=%b want 0001", bus.req_ready); end
        note_accept(0, model_of(0));
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        e = q.pop_front();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== e.id || bus.out_data !== e.data) begin
            tests_failed++;
            $display("FAIL rm_first_out got v=%b id=%0d data=%b want v=1 id=%0d data=%b",
                     bus.out_valid, bus.out_id, bus.out_data, e.id, e.data);
        end
    endtask

    initial begin
        clk            = 1'b0;
        rst            = 1'b1;
        tests_run      = 0;
        tests_failed   = 0;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.req_len    = '0;
        bus.req_signed = '0;
        bus.out_ready  = 1'b0;
        model_reset();

        test_reset();
        test_extend();
        test_round_robin();
        test_backpressure();
        test_reset_mid();

        tests_run++;
        if (q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_leftover got=%0d want=0", q.size()); end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
